// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size encodings,
// the FSM state type and the request legality check.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // A request is rejected for an illegal size, a misaligned half or word,
  // or a word index beyond the storage depth.
  function automatic logic dmem_req_error(input logic [1:0]  size,
                                          input logic [31:0] addr,
                                          input int unsigned depth);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr[0];
      SIZE_W:  bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= depth) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: extracts and extends load data
// from a stored word, and merges right-aligned store data into it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, sign/zero extension and store merge for each access size.
  always_comb begin
    byte_v       = old_word_i[{addr_lo_i, 3'b000} +: 8];
    half_v       = old_word_i[{addr_lo_i[1], 4'b0000} +: 16];
    load_data_o  = '0;
    store_word_o = old_word_i;
    case (size_i)
      SIZE_B: begin
        load_data_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
        store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_H: begin
        load_data_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
        store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      SIZE_W: begin
        load_data_o  = old_word_i;
        store_word_o = wdata_i;
      end
      default: begin
        load_data_o  = '0;
        store_word_o = old_word_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory slave: one request at a time, registered response.
// Optional wait states are enabled by defining DMEM_WAITSTATE_EN; without it
// the WAIT state and counter are absent and every response takes one cycle.
//
// state | meaning
// IDLE  | ready for a request; error or zero-wait accesses resolve here
// WAIT  | counting down wait states; access happens when count reaches 1
// RESP  | response held on resp_* until the core takes it
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
)
(
  input  logic        clock,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be within 0..15");
  end

  dmem_state_e state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic            acc_write;
  logic [IDXW+1:0] acc_addr;
  logic [1:0]      acc_size;
  logic            acc_unsigned;
  logic [31:0]     acc_wdata;
  logic            mem_we;
  logic [31:0]     load_word;
  logic [31:0]     store_word;
  logic            req_err;

`ifdef DMEM_WAITSTATE_EN
  // Request fields are only needed past the accept edge when wait states
  // delay the access; otherwise the access uses the live request directly.
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [IDXW+1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [31:0]     wdata_q, wdata_d;
`endif

  assign req_err = dmem_req_error(req_size, req_addr, DEPTH_WORDS);

  // Access operands: live request in IDLE, captured request in WAIT.
  always_comb begin
    acc_write    = req_write;
    acc_addr     = req_addr[IDXW+1:0];
    acc_size     = req_size;
    acc_unsigned = req_unsigned;
    acc_wdata    = req_wdata;
`ifdef DMEM_WAITSTATE_EN
    if (state_q == WAIT) begin
      acc_write    = write_q;
      acc_addr     = addr_q;
      acc_size     = size_q;
      acc_unsigned = unsigned_q;
      acc_wdata    = wdata_q;
    end
`endif
  end

  dmem_lane_align u_lane_align (
    .addr_lo_i    (acc_addr[1:0]),
    .size_i       (acc_size),
    .unsigned_i   (acc_unsigned),
    .old_word_i   (mem_q[acc_addr[IDXW+1:2]]),
    .wdata_i      (acc_wdata),
    .load_data_o  (load_word),
    .store_word_o (store_word)
  );

  // Next-state, response data and storage write enable.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
`ifdef DMEM_WAITSTATE_EN
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef DMEM_WAITSTATE_EN
          write_d    = req_write;
          addr_d     = req_addr[IDXW+1:0];
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
`endif
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
`ifdef DMEM_WAITSTATE_EN
            if (WAIT_CYCLES > 0) begin
              cnt_d   = 4'(WAIT_CYCLES);
              err_d   = 1'b0;
              rdata_d = '0;
              state_d = WAIT;
            end else begin
              mem_we  = acc_write;
              rdata_d = acc_write ? '0 : load_word;
              err_d   = 1'b0;
              state_d = RESP;
            end
`else
            mem_we  = acc_write;
            rdata_d = acc_write ? '0 : load_word;
            err_d   = 1'b0;
            state_d = RESP;
`endif
          end
        end
      end
`ifdef DMEM_WAITSTATE_EN
      WAIT: begin
        if (cnt_q == 4'd1) begin
          mem_we  = acc_write;
          rdata_d = acc_write ? '0 : load_word;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_WAITSTATE_EN
      cnt_q      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_WAITSTATE_EN
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
`endif
    end
  end

  // Storage is not cleared by reset; a reset coinciding with the access
  // edge discards the write.
  always_ff @(posedge clock) begin
    if (!rst && mem_we) mem_q[acc_addr[IDXW+1:2]] <= store_word;
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAITS = 2;
`ifdef DMEM_WAITSTATE_EN
  localparam int LAT_OK = 1 + WAITS;
`else
  localparam int LAT_OK = 1;
`endif

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int passed = 0;
  int total  = 0;

  logic [31:0] rd;
  logic        er, st, hs;
  int          lat;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clock        (clock),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  // Drives one request, scrambles the request inputs after acceptance,
  // measures latency in edges, holds resp_ready low for 'hold' cycles, then
  // completes the handshake. Returns observations only.
  task automatic run_req(input logic wr, input logic [31:0] addr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] rdo, output logic ero,
                         output int lato, output logic stable,
                         output logic hs_ok);
    int n;
    logic rdy0;
    rdy0 = req_ready;
    req_write = wr; req_addr = addr; req_size = sz;
    req_unsigned = uns; req_wdata = wd; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_size = ~sz;
    req_unsigned = ~uns; req_wdata = ~wd;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    lato = resp_valid ? n + 1 : -1;
    rdo = resp_rdata;
    ero = resp_err;
    stable = 1'b1;
    repeat (hold) begin
      @(posedge clock); #1;
      if (!resp_valid || req_ready || resp_rdata !== rdo || resp_err !== ero)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    hs_ok = rdy0 && !resp_valid && req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %b want 1", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL reset resp_valid: got %b want 0", resp_valid); else passed++;
    total++; if (resp_rdata !== 32'h0) $display("FAIL reset resp_rdata: got %h want 00000000", resp_rdata); else passed++;
    total++; if (resp_err !== 1'b0) $display("FAIL reset resp_err: got %b want 0", resp_err); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_word();
    run_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sw_0x10: got rdata=%h err=%b want 00000000/0", rd, er); else passed++;
    total++; if (lat !== LAT_OK) $display("FAIL sw_0x10 latency: got %0d want %0d", lat, LAT_OK); else passed++;
    total++; if (hs !== 1'b1) $display("FAIL sw_0x10 handshake: got %b want 1", hs); else passed++;
    run_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw_0x10: got rdata=%h err=%b want deadbeef/0", rd, er); else passed++;
    total++; if (lat !== LAT_OK) $display("FAIL lw_0x10 latency: got %0d want %0d", lat, LAT_OK); else passed++;
  endtask

  task automatic test_byte_half();
    run_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'hFFFFFFDE) $display("FAIL lb_0x13: got %h want ffffffde", rd); else passed++;
    run_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'h000000DE) $display("FAIL lbu_0x13: got %h want 000000de", rd); else passed++;
    run_req(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'hFFFFDEAD) $display("FAIL lh_0x12: got %h want ffffdead", rd); else passed++;
    run_req(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'h0000DEAD) $display("FAIL lhu_0x12: got %h want 0000dead", rd); else passed++;
    run_req(1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'hFFFFBEEF) $display("FAIL lh_0x10: got %h want ffffbeef", rd); else passed++;
    run_req(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'hFFFFFFBE) $display("FAIL lb_0x11: got %h want ffffffbe", rd); else passed++;
    run_req(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_unsigned_0x10: got %h want deadbeef", rd); else passed++;
  endtask

  task automatic test_store_merge();
    run_req(1'b1, 32'h11, 2'b00, 1'b0, 32'hAAAAAA55, 0, rd, er, lat, st, hs);
    run_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'hDEAD55EF) $display("FAIL sb_merge: got %h want dead55ef", rd); else passed++;
    run_req(1'b1, 32'h11, 2'b01, 1'b0, 32'h00001234, 0, rd, er, lat, st, hs);
    total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL sh_misaligned: got err=%b rdata=%h want 1/00000000", er, rd); else passed++;
    total++; if (lat !== 1) $display("FAIL sh_misaligned latency: got %0d want 1", lat); else passed++;
    run_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'hDEAD55EF) $display("FAIL after_bad_sh: got %h want dead55ef", rd); else passed++;
    run_req(1'b1, 32'h12, 2'b01, 1'b0, 32'h1234A5A5, 0, rd, er, lat, st, hs);
    run_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'hA5A555EF) $display("FAIL sh_merge_0x12: got %h want a5a555ef", rd); else passed++;
  endtask

  task automatic test_errors();
    run_req(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lw_out_of_range: got err=%b rdata=%h want 1/00000000", er, rd); else passed++;
    total++; if (lat !== 1) $display("FAIL lw_out_of_range latency: got %0d want 1", lat); else passed++;
    run_req(1'b0, 32'h0, 2'b11, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (er !== 1'b1) $display("FAIL size_11: got err=%b want 1", er); else passed++;
    run_req(1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (er !== 1'b1) $display("FAIL lw_misaligned: got err=%b want 1", er); else passed++;
    run_req(1'b0, 32'h80000010, 2'b00, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (er !== 1'b1) $display("FAIL lb_high_addr: got err=%b want 1", er); else passed++;
    run_req(1'b1, 32'h3FC, 2'b10, 1'b0, 32'hCAFEF00D, 0, rd, er, lat, st, hs);
    total++; if (er !== 1'b0) $display("FAIL sw_last_word err: got %b want 0", er); else passed++;
    run_req(1'b0, 32'h3FF, 2'b00, 1'b1, 32'h0, 0, rd, er, lat, st, hs);
    total++; if (rd !== 32'h000000CA || er !== 1'b0) $display("FAIL lbu_last_byte: got rdata=%h err=%b want 000000ca/0", rd, er); else passed++;
  endtask

  task automatic test_hold();
    run_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 3, rd, er, lat, st, hs);
    total++; if (st !== 1'b1) $display("FAIL hold_stable: got %b want 1", st); else passed++;
    total++; if (rd !== 32'hA5A555EF) $display("FAIL hold_rdata: got %h want a5a555ef", rd); else passed++;
    total++; if (hs !== 1'b1) $display("FAIL hold_handshake: got %b want 1", hs); else passed++;
  endtask

  task automatic test_reset_mid();
    run_req(1'b1, 32'h20, 2'b10, 1'b0, 32'h0BADF00D, 0, rd, er, lat, st, hs);
    req_write = 1'b1; req_addr = 32'h20; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clock); #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_mid handshake: got valid=%b ready=%b want 0/1", resp_valid, req_ready); else passed++;
    total++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) $display("FAIL rst_mid outputs: got rdata=%h err=%b want 00000000/0", resp_rdata, resp_err); else passed++;
    rst = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_mid no late resp: got %b want 0", resp_valid); else passed++;
    run_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er, lat, st, hs);
`ifdef DMEM_WAITSTATE_EN
    total++; if (rd !== 32'h0BADF00D) $display("FAIL rst_in_wait store discarded: got %h want 0badf00d", rd); else passed++;
`else
    total++; if (rd !== 32'h12345678) $display("FAIL rst_in_resp store kept: got %h want 12345678", rd); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_store_merge();
    test_errors();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-memory load/store interface. Accepts one request at a time from the core over a valid/ready handshake, performs a byte, half or word access into an internal word-organised array, and returns a registered response with read data or an error flag. Sits between the core's memory stage and storage, replacing a zero-latency combinational data memory with a handshaked, optionally wait-stated slave.

## Interface
- DEPTH_WORDS, 256: number of 32-bit storage words; word index is addr[31:2].
- WAIT_CYCLES, 2: extra access latency in cycles, used only when DMEM_WAITSTATE_EN is defined; legal 0..15.
- clock  in  1  single clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0]).
- req_unsigned  in  1  zero-extend load data (funct3[2]).
- req_wdata  in  32  store data, right-aligned (lane 0 = bits 7:0).
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes the response.
- resp_rdata  out  32  load data, already extended; 0 for stores and errors.
- resp_err  out  1  request was misaligned, out of range or illegal size.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture all req_* fields. If error, go to RESP with resp_err=1 and no storage access. Else if DMEM_WAITSTATE_EN and WAIT_CYCLES>0, load counter with WAIT_CYCLES and go to WAIT. Else perform access and go to RESP.
- WAIT: decrement counter each cycle; at count 1, perform access and go to RESP on the next edge.
- RESP: resp_valid=1, resp_rdata and resp_err stable. Return to IDLE on resp_ready=1; otherwise hold indefinitely.
- Error conditions: size 11; half with addr[0]=1; word with addr[1:0]!=00; addr[31:2] >= DEPTH_WORDS.
- Load: select lane(s) by addr[1:0], sign-extend from bit 7 (byte) or 15 (half) unless req_unsigned=1. Word loads ignore req_unsigned.
- Store: merge req_wdata[7:0] or [15:0] into the addressed lanes. Other lanes are unchanged. Word stores replace all lanes.
- Storage is written only in the access cycle and never on error.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter 0. Storage contents are not cleared.
- Request accepted at edge N (req_valid && req_ready).
  - Without the macro: resp_valid is high from edge N+1.
  - With the macro: resp_valid is high from edge N+1+WAIT_CYCLES.
- Error responses always appear at N+1, regardless of the macro.
- Store visible to a subsequent load from the cycle after the access edge.
- req_ready is low in WAIT and RESP. The earliest next acceptance is the edge after the resp handshake. Maximum throughput is 1 request per 2 cycles.
- resp_valid and resp_ready both high at edge M: state is IDLE and resp_valid=0 after M.
- rst during WAIT: the pending store is discarded. rst during RESP: the response is dropped. An access already performed is not undone.
- Request inputs are sampled only at the accept edge; later changes are ignored.

## Configuration
- DMEM_WAITSTATE_EN defined: the WAIT state and its 4-bit counter exist, and successful accesses take 1+WAIT_CYCLES cycles.
- DMEM_WAITSTATE_EN undefined: the WAIT state and counter are compiled out, WAIT_CYCLES is ignored, and every response arrives one cycle after acceptance.

## Structure
- Shared package dmem_pkg:
  - size encodings SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - the state enum (IDLE, WAIT, RESP);
  - the error-check function (size, addr, depth).
- Sub-module dmem_lane_align (combinational): load extract/extend and store merge, given addr[1:0], size, unsigned flag, old word and new data. The top level holds the FSM, counter, capture registers and array.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
- Load byte from 0x13 after the above: signed -> 0xFFFFFFDE; unsigned -> 0x000000DE. Load half from 0x12: signed -> 0xFFFFDEAD.
- Store byte 0x55 to 0x11, then load word 0x10 -> 0xDEAD55EF. Half store to 0x11 -> resp_err=1, and a following word load from 0x10 is still 0xDEAD55EF.
- Word load at address 4*DEPTH_WORDS -> resp_err=1, resp_rdata=0, response at N+1.
- With DMEM_WAITSTATE_EN and WAIT_CYCLES=2: accept at edge 5 -> resp_valid at edge 8. Holding resp_ready=0 for 3 cycles keeps data stable and req_ready=0.
- rst asserted in WAIT during a store of 0x12345678 to 0x20 -> outputs at reset values next cycle, and a later load of 0x20 returns the prior value.
